// File: rtl/rl_sink.sv
// rl_sink: debounced 12-bit word capture into a small FIFO, drained through
// a dav_/rfd handshake. Optional dropped-word counter: RL_SINK_DROPCNT_EN.
module rl_sink #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset_,
  input  logic [3:0]  a3_a0,
  input  logic [7:0]  z7_z0,
  input  logic        rfd,
  output logic        dav_,
  output logic [11:0] q11_q0
`ifdef RL_SINK_DROPCNT_EN
  ,
  output logic [7:0]  ovf7_ovf0
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S0_IDLE,
    S1_PRESENT,
    S2_RELEASE
  } state_t;

  logic [11:0] word;
  logic [11:0] prev_q, prev_d;
  logic [11:0] last_q, last_d;
  logic [11:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  state_t        state_q, state_d;
  logic          dav_q, dav_d;
  logic [11:0]   dout_q, dout_d;
  logic          accept, full, empty, push, pop;
`ifdef RL_SINK_DROPCNT_EN
  logic [7:0]    ovf_q, ovf_d;
  logic          drop;
`endif

  assign word  = {a3_a0, z7_z0};
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    state_d = state_q;
    dav_d   = dav_q;
    dout_d  = dout_q;
    pop     = 1'b0;
    unique case (state_q)
      S0_IDLE: begin
        if (!empty && rfd) begin
          dout_d  = mem_q[rd_ptr_q];
          dav_d   = 1'b0;
          state_d = S1_PRESENT;
        end
      end
      S1_PRESENT: begin
        if (!rfd) begin
          dav_d   = 1'b1;
          pop     = 1'b1;
          state_d = S2_RELEASE;
        end
      end
      S2_RELEASE: begin
        if (rfd) state_d = S0_IDLE;
      end
      default: state_d = S0_IDLE;
    endcase
  end

  // A pop on this edge frees a slot, so a full FIFO can still take the word.
  always_comb begin
    accept   = (word == prev_q) && (word != last_q);
    push     = accept && (!full || pop);
    prev_d   = word;
    last_d   = accept ? word : last_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + (AW+1)'(1);
    if (pop && !push) count_d = count_q - (AW+1)'(1);
  end

`ifdef RL_SINK_DROPCNT_EN
  always_comb begin
    drop  = accept && full && !pop;
    ovf_d = (drop && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset_ && push) mem_q[wr_ptr_q] <= word;
  end

  always_ff @(posedge clock) begin
    if (!reset_) begin
      prev_q   <= '0;
      last_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= S0_IDLE;
      dav_q    <= 1'b1;
      dout_q   <= '0;
`ifdef RL_SINK_DROPCNT_EN
      ovf_q    <= '0;
`endif
    end else begin
      prev_q   <= prev_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      dav_q    <= dav_d;
      dout_q   <= dout_d;
`ifdef RL_SINK_DROPCNT_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign dav_   = dav_q;
  assign q11_q0 = dout_q;
`ifdef RL_SINK_DROPCNT_EN
  assign ovf7_ovf0 = ovf_q;
`endif

endmodule
